// File: rtl/adc_stream_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_stream_pkg
// Purpose  : Tag codes, parser state encoding and error-bit positions shared by
//            the ADC capture stream producer and adc_stream_parser.
// Revision : 1.0 - initial release
// ============================================================================
package adc_stream_pkg;

    localparam logic [1:0] TAG_CNT_LO = 2'b00;
    localparam logic [1:0] TAG_CNT_HI = 2'b01;
    localparam logic [1:0] TAG_DATA   = 2'b10;
    localparam logic [1:0] TAG_END    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    localparam int ERR_ORPHAN = 0;
    localparam int ERR_SEQ    = 1;
    localparam int ERR_NO_END = 2;
    localparam int ERR_SAT    = 3;
    localparam int ERR_WIDTH  = 4;

endpackage
`default_nettype wire

// File: rtl/adc_stream_parser_outreg.sv
`default_nettype none
// ============================================================================
// Module   : adc_sample_outreg
// Purpose  : Valid/ready output register for one parsed sample (a, b, idx and,
//            with PARSER_SUMABS_EN defined, |a|+|b|).
// Revision : 1.0 - initial release
// ============================================================================
module adc_sample_outreg #(
    parameter int SAMPLE_WIDTH = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic                    ready,
    input  logic [SAMPLE_WIDTH-1:0] a_in,
    input  logic [SAMPLE_WIDTH-1:0] b_in,
    input  logic [CNT_WIDTH-1:0]    idx_in,
`ifdef PARSER_SUMABS_EN
    input  logic [SAMPLE_WIDTH:0]   sumabs_in,
    output logic [SAMPLE_WIDTH:0]   sumabs,
`endif
    output logic                    valid,
    output logic [SAMPLE_WIDTH-1:0] a,
    output logic [SAMPLE_WIDTH-1:0] b,
    output logic [CNT_WIDTH-1:0]    idx
);

    // The parent only asserts load when the register is empty or draining,
    // so a load never overwrites an unconsumed sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid  <= 1'b0;
            a      <= '0;
            b      <= '0;
            idx    <= '0;
`ifdef PARSER_SUMABS_EN
            sumabs <= '0;
`endif
        end else if (load) begin
            valid  <= 1'b1;
            a      <= a_in;
            b      <= b_in;
            idx    <= idx_in;
`ifdef PARSER_SUMABS_EN
            sumabs <= sumabs_in;
`endif
        end else if (ready) begin
            valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_stream_parser.sv
`default_nettype none
// ============================================================================
// Module   : adc_stream_parser
// Purpose  : Rebuilds ADC bursts from 32-bit tagged AXI-Stream words; emits
//            samples, burst strobes/timestamp/length and sticky errors.
//            Optional feature macro: PARSER_SUMABS_EN (|a|+|b| and burst peak).
// Revision : 1.0 - initial release
// ============================================================================
module adc_stream_parser
    import adc_stream_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [31:0]                    s_axis_tdata,
    output logic                           m_sample_valid,
    input  logic                           m_sample_ready,
    output logic signed [SAMPLE_WIDTH-1:0] m_sample_a,
    output logic signed [SAMPLE_WIDTH-1:0] m_sample_b,
    output logic [CNT_WIDTH-1:0]           m_sample_idx,
`ifdef PARSER_SUMABS_EN
    output logic [SAMPLE_WIDTH:0]          m_sample_sumabs,
    output logic [SAMPLE_WIDTH:0]          burst_peak,
`endif
    input  logic                           accept_headerless,
    input  logic                           clear_errors,
    output logic                           burst_start,
    output logic                           burst_done,
    output logic [59:0]                    burst_ts,
    output logic                           ts_valid,
    output logic [CNT_WIDTH-1:0]           burst_len,
    output logic [CNT_WIDTH-1:0]           total_samples,
    output logic [ERR_WIDTH-1:0]           err_flags
);

    state_t                  r_state;
    logic [29:0]             r_ts_lo;
    logic [CNT_WIDTH-1:0]    r_idx;

    logic                    w_xfer;
    logic                    w_emit;
    logic [1:0]              w_tag;
    logic [29:0]             w_payload;
    logic [SAMPLE_WIDTH-1:0] w_a;
    logic [SAMPLE_WIDTH-1:0] w_b;
    logic [CNT_WIDTH-1:0]    w_emit_idx;
    logic [CNT_WIDTH-1:0]    w_idx_next;
    logic [CNT_WIDTH-1:0]    w_total_next;
    logic [ERR_WIDTH-1:0]    w_err_set;

    assign s_axis_tready = !m_sample_valid || m_sample_ready;
    assign w_xfer        = s_axis_tvalid && s_axis_tready;
    assign w_tag         = s_axis_tdata[31:30];
    assign w_payload     = s_axis_tdata[29:0];
    assign w_a           = w_payload[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign w_b           = w_payload[SAMPLE_WIDTH-1:0];

    // A headerless burst opens on its first sample, which is index 0.
    assign w_emit_idx   = (r_state == S_IDLE) ? '0 : r_idx;
    assign w_idx_next   = (w_emit_idx == '1) ? w_emit_idx : w_emit_idx + CNT_WIDTH'(1);
    assign w_total_next = (total_samples == '1) ? total_samples : total_samples + CNT_WIDTH'(1);

    always_comb begin
        w_emit    = 1'b0;
        w_err_set = '0;
        if (w_xfer) begin
            case (r_state)
                S_IDLE: begin
                    if (w_tag == TAG_DATA) begin
                        if (accept_headerless) w_emit = 1'b1;
                        else                   w_err_set[ERR_ORPHAN] = 1'b1;
                    end else if (w_tag != TAG_CNT_LO) begin
                        w_err_set[ERR_SEQ] = 1'b1;
                    end
                end
                S_HDR: begin
                    if (w_tag != TAG_CNT_HI) w_err_set[ERR_SEQ] = 1'b1;
                end
                S_BURST: begin
                    case (w_tag)
                        TAG_DATA:   w_emit = 1'b1;
                        TAG_CNT_LO: w_err_set[ERR_NO_END] = 1'b1;
                        TAG_CNT_HI: w_err_set[ERR_SEQ] = 1'b1;
                        default:    ;
                    endcase
                end
                default: ;
            endcase
        end
        if (w_emit && (w_idx_next == '1 || w_total_next == '1))
            w_err_set[ERR_SAT] = 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_ts_lo       <= '0;
            r_idx         <= '0;
            burst_start   <= 1'b0;
            burst_done    <= 1'b0;
            burst_ts      <= '0;
            ts_valid      <= 1'b0;
            burst_len     <= '0;
            total_samples <= '0;
            err_flags     <= '0;
        end else begin
            burst_start <= 1'b0;
            burst_done  <= 1'b0;
            // A bit raised this cycle survives a simultaneous clear.
            err_flags   <= (clear_errors ? '0 : err_flags) | w_err_set;
            if (w_emit) begin
                r_idx         <= w_idx_next;
                total_samples <= w_total_next;
            end
            if (w_xfer) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_tag == TAG_CNT_LO) begin
                            r_ts_lo <= w_payload;
                            r_state <= S_HDR;
                        end else if (w_tag == TAG_DATA && accept_headerless) begin
                            burst_start <= 1'b1;
                            ts_valid    <= 1'b0;
                            burst_ts    <= '0;
                            r_state     <= S_BURST;
                        end
                    end
                    S_HDR: begin
                        case (w_tag)
                            TAG_CNT_HI: begin
                                burst_ts    <= {w_payload, r_ts_lo};
                                ts_valid    <= 1'b1;
                                burst_start <= 1'b1;
                                r_idx       <= '0;
                                r_state     <= S_BURST;
                            end
                            TAG_CNT_LO: r_ts_lo <= w_payload;
                            default:    r_state <= S_IDLE;
                        endcase
                    end
                    S_BURST: begin
                        if (w_tag != TAG_DATA) begin
                            burst_len  <= r_idx;
                            burst_done <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                        // A new header inside a burst closes it and starts the next one.
                        if (w_tag == TAG_CNT_LO) begin
                            r_ts_lo <= w_payload;
                            r_state <= S_HDR;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

`ifdef PARSER_SUMABS_EN
    localparam logic [SAMPLE_WIDTH-1:0] MOST_NEG = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

    function automatic logic [SAMPLE_WIDTH-1:0] abs_clamp(input logic [SAMPLE_WIDTH-1:0] v);
        if (!v[SAMPLE_WIDTH-1]) return v;
        else if (v == MOST_NEG) return ~MOST_NEG;
        else                    return -v;
    endfunction

    logic [SAMPLE_WIDTH:0] w_sumabs;
    assign w_sumabs = {1'b0, abs_clamp(w_a)} + {1'b0, abs_clamp(w_b)};

    always_ff @(posedge aclk) begin
        if (areset) begin
            burst_peak <= '0;
        end else if (w_xfer && r_state == S_HDR && w_tag == TAG_CNT_HI) begin
            burst_peak <= '0;
        end else if (w_emit && (r_state == S_IDLE || w_sumabs > burst_peak)) begin
            burst_peak <= w_sumabs;
        end
    end
`endif

    adc_sample_outreg #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH),
        .CNT_WIDTH    (CNT_WIDTH)
    ) u_outreg (
        .clk       (aclk),
        .rst       (areset),
        .load      (w_emit),
        .ready     (m_sample_ready),
        .a_in      (w_a),
        .b_in      (w_b),
        .idx_in    (w_emit_idx),
`ifdef PARSER_SUMABS_EN
        .sumabs_in (w_sumabs),
        .sumabs    (m_sample_sumabs),
`endif
        .valid     (m_sample_valid),
        .a         (m_sample_a),
        .b         (m_sample_b),
        .idx       (m_sample_idx)
    );

endmodule
`default_nettype wire

// File: tb/tb_adc_stream_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_stream_parser
// Purpose  : Self-checking bench for adc_stream_parser: directed bursts plus
//            random traffic compared every cycle against a transaction model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_stream_parser;

    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [31:0]   tdata = '0;
    logic          mvalid;
    logic          mready = 1'b1;
    logic [14:0]   ma, mb;
    logic [CW-1:0] midx;
    logic          hdl = 1'b0;
    logic          clr = 1'b0;
    logic          bstart, bdone, tsv;
    logic [59:0]   bts;
    logic [CW-1:0] blen, total;
    logic [3:0]    err;
`ifdef PARSER_SUMABS_EN
    logic [15:0]   sumabs, peak;
`endif

    always #5 clk = ~clk;

    adc_stream_parser #(.SAMPLE_WIDTH(15), .CNT_WIDTH(CW)) dut (
        .aclk              (clk),
        .areset            (areset),
        .s_axis_tvalid     (tvalid),
        .s_axis_tready     (tready),
        .s_axis_tdata      (tdata),
        .m_sample_valid    (mvalid),
        .m_sample_ready    (mready),
        .m_sample_a        (ma),
        .m_sample_b        (mb),
        .m_sample_idx      (midx),
`ifdef PARSER_SUMABS_EN
        .m_sample_sumabs   (sumabs),
        .burst_peak        (peak),
`endif
        .accept_headerless (hdl),
        .clear_errors      (clr),
        .burst_start       (bstart),
        .burst_done        (bdone),
        .burst_ts          (bts),
        .ts_valid          (tsv),
        .burst_len         (blen),
        .total_samples     (total),
        .err_flags         (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model, one transaction per accepted word.
    bit          in_burst, hdr_pending;
    logic [29:0] ts_lo;
    int          cur_idx, tot;
    bit          e_ov, e_start, e_done, e_tsv;
    logic [14:0] e_a, e_b;
    int          e_idx, e_len;
    logic [59:0] e_ts;
    logic [3:0]  e_err;
    bit          last_xfer;

    task automatic model_word(input logic [31:0] d, input bit xfer);
        logic [1:0]  tag = d[31:30];
        logic [29:0] p   = d[29:0];
        logic [3:0]  e   = '0;
        bit          emit = 0;
        if (areset) begin
            in_burst = 0; hdr_pending = 0; ts_lo = '0; cur_idx = 0; tot = 0;
            e_ov = 0; e_start = 0; e_done = 0; e_tsv = 0; e_a = '0; e_b = '0;
            e_idx = 0; e_len = 0; e_ts = '0; e_err = '0;
            return;
        end
        e_start = 0;
        e_done  = 0;
        if (e_ov && mready) e_ov = 0;
        if (xfer) begin
            if (in_burst) begin
                if (tag == 2'b10) emit = 1;
                else begin
                    e_len = cur_idx; e_done = 1; in_burst = 0;
                    if (tag == 2'b00) begin e[2] = 1; ts_lo = p; hdr_pending = 1; end
                    if (tag == 2'b01) e[1] = 1;
                end
            end else if (hdr_pending) begin
                if (tag == 2'b01) begin
                    e_ts = {p, ts_lo}; e_tsv = 1; e_start = 1; cur_idx = 0;
                    in_burst = 1; hdr_pending = 0;
                end else if (tag == 2'b00) begin
                    e[1] = 1; ts_lo = p;
                end else begin
                    e[1] = 1; hdr_pending = 0;
                end
            end else begin
                if (tag == 2'b00) begin ts_lo = p; hdr_pending = 1; end
                else if (tag == 2'b10) begin
                    if (hdl) begin
                        e_start = 1; e_tsv = 0; e_ts = '0; cur_idx = 0; in_burst = 1; emit = 1;
                    end else e[0] = 1;
                end else e[1] = 1;
            end
            if (emit) begin
                e_ov = 1; e_a = p[29:15]; e_b = p[14:0]; e_idx = cur_idx;
                if (cur_idx < CMAX) cur_idx++;
                if (tot < CMAX) tot++;
                if (cur_idx == CMAX || tot == CMAX) e[3] = 1;
            end
        end
        e_err = (clr ? 4'h0 : e_err) | e;
    endtask

    task automatic step(input bit v, input logic [31:0] d, input bit rdy);
        bit exp_rdy;
        @(negedge clk);
        tvalid = v;
        tdata  = d;
        mready = rdy;
        #1;
        exp_rdy = !e_ov || rdy;
        check("tready", tready, exp_rdy);
        last_xfer = v && exp_rdy;
        model_word(d, last_xfer);
        @(posedge clk);
        #1;
        check("m_valid", mvalid, e_ov);
        if (e_ov) begin
            check("m_a", ma, e_a);
            check("m_b", mb, e_b);
            check("m_idx", midx, e_idx);
        end
        check("burst_start", bstart, e_start);
        check("burst_done", bdone, e_done);
        check("burst_ts", bts, e_ts);
        check("ts_valid", tsv, e_tsv);
        check("burst_len", blen, e_len);
        check("total", total, tot);
        check("err", err, e_err);
    endtask

    function automatic logic [31:0] wd(input logic [1:0] tag, input logic [29:0] p);
        return {tag, p};
    endfunction

    function automatic logic [31:0] smp(input int a, input int b);
        logic [14:0] a15 = 15'(a);
        logic [14:0] b15 = 15'(b);
        return {2'b10, a15, b15};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 1);
    endtask

    initial begin
        // Reset
        areset = 1; idle(2); areset = 0;
        check("rst_err", err, 4'h0);
        check("rst_tready", tready, 1'b1);

        // 1: headed burst of three samples
        step(1, wd(2'b00, 30'h5), 1);
        step(1, wd(2'b01, 30'h1), 1);
        check("t1_ts", bts, 64'h4000_0005);
        check("t1_tsv", tsv, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1, smp(256, -256), 1);
            check("t1_a", ma, 15'd256);
            check("t1_b", mb, 15'h7F00);
            check("t1_idx", midx, i);
        end
        step(1, wd(2'b11, '0), 1);
        check("t1_len", blen, 3);
        check("t1_err", err, 4'h0);
        idle(1);

        // 2: orphan sample, clear, then headerless burst; set wins over clear
        step(1, smp(1, 2), 1);
        check("t2_orphan", err, 4'h1);
        check("t2_noout", mvalid, 1'b0);
        clr = 1; idle(1); clr = 0;
        check("t2_clr", err, 4'h0);
        hdl = 1;
        step(1, smp(1, 2), 1);
        check("t2_start", bstart, 1'b1);
        check("t2_tsv", tsv, 1'b0);
        check("t2_idx", midx, 0);
        hdl = 0;
        step(1, wd(2'b11, '0), 1);
        clr = 1;
        step(1, wd(2'b11, '0), 1);
        clr = 0;
        check("t2_setwins", err, 4'h2);
        clr = 1; idle(1); clr = 0;

        // 3: missing end, implicit close, new header
        step(1, wd(2'b00, 30'h9), 1);
        step(1, wd(2'b01, 30'h0), 1);
        step(1, smp(5, 6), 1);
        step(1, smp(7, 8), 1);
        step(1, wd(2'b00, 30'h7), 1);
        check("t3_done", bdone, 1'b1);
        check("t3_len", blen, 2);
        check("t3_err", err, 4'h4);
        step(1, wd(2'b01, 30'h0), 1);
        check("t3_ts", bts, 64'h7);
        step(1, wd(2'b11, '0), 1);
        clr = 1; idle(1); clr = 0;

        // 4: back-pressure on cycles 2-4 of five back-to-back samples
        step(1, wd(2'b00, 30'h1), 1);
        step(1, wd(2'b01, 30'h2), 1);
        begin
            int k = 0;
            for (int c = 0; c < 40 && k < 5; c++) begin
                step(1, smp(100 + k, -k), !(c >= 2 && c <= 4));
                if (last_xfer) k++;
            end
            check("t4_all_sent", k, 5);
        end
        step(1, wd(2'b11, '0), 1);
        idle(2);

        // 5: reset in mid-burst
        step(1, wd(2'b00, 30'h3), 1);
        step(1, wd(2'b01, 30'h4), 1);
        step(1, smp(9, 9), 0);
        areset = 1; idle(1); areset = 0;
        check("t5_done", bdone, 1'b0);
        check("t5_valid", mvalid, 1'b0);
        check("t5_total", total, 0);
        step(1, smp(9, 9), 1);
        check("t5_orphan", err, 4'h1);
        clr = 1; idle(1); clr = 0;

        // Counter saturation: a burst longer than the counters can hold
        step(1, wd(2'b00, 30'h0), 1);
        step(1, wd(2'b01, 30'h0), 1);
        for (int i = 0; i < CMAX + 6; i++) step(1, smp(i, i), 1);
        step(1, wd(2'b11, '0), 1);
        check("sat_len", blen, CMAX);
        check("sat_total", total, CMAX);
        check("sat_err", err[3], 1'b1);
        idle(1);

`ifdef PARSER_SUMABS_EN
        // 6: |a|+|b| and burst peak
        step(1, wd(2'b00, 30'h0), 1);
        step(1, wd(2'b01, 30'h0), 1);
        step(1, smp(-3, 4), 1);
        check("t6_s0", sumabs, 7);
        step(1, smp(10, -10), 1);
        check("t6_s1", sumabs, 20);
        step(1, smp(1, 1), 1);
        check("t6_s2", sumabs, 2);
        step(1, wd(2'b11, '0), 1);
        check("t6_peak", peak, 20);
        idle(1);
`endif

        // Random traffic with back-pressure, clears and rare resets
        areset = 1; idle(1); areset = 0;
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            logic [1:0] tag;
            if (hdr_pending && r < 70) tag = 2'b01;
            else if (r < 15)           tag = 2'b00;
            else if (r < 22)           tag = 2'b01;
            else if (r < 90)           tag = 2'b10;
            else                       tag = 2'b11;
            hdl    = ($urandom_range(0, 9) < 7);
            clr    = ($urandom_range(0, 49) == 0);
            areset = ($urandom_range(0, 499) == 0);
            step($urandom_range(0, 3) != 0, wd(tag, 30'($urandom)), $urandom_range(0, 9) < 7);
        end
        areset = 0; clr = 0; hdl = 0;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
